fc_layer_ctrl: RTL and testbench
================================

FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 16, signed fixed-point width of inputs, weights, biases and outputs.
REQ-002 Parameter FRAC_BITS, 8, fractional bits of every DATA_WIDTH operand.
REQ-003 Parameter INPUT_NODES, 100, input vector length (>=2).
REQ-004 Parameter OUTPUT_NODES, 32, output vector length and number of MAC lanes (>=1).
REQ-005 Localparam ACC_WIDTH = 2*DATA_WIDTH + clog2(INPUT_NODES); the accumulator never overflows.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  request to begin one layer evaluation.
REQ-009 relu_en  input  1  enables ReLU on outputs; sampled with start.
REQ-010 input_fc  input  DATA_WIDTH*INPUT_NODES  input vector; node j occupies bits [DATA_WIDTH*j +: DATA_WIDTH]; sampled with start.
REQ-011 bias  input  DATA_WIDTH*OUTPUT_NODES  per-node bias; sampled in FINISH.
REQ-012 w_valid  input  1  weight row present on weights.
REQ-013 w_ready  output  1  block consumes a weight row this cycle.
REQ-014 weights  input  DATA_WIDTH*OUTPUT_NODES  one weight row: lane k holds the weight from the current input node to output node k.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 out_valid  output  1  output_fc holds a completed result.
REQ-017 out_ready  input  1  consumer accepts output_fc.
REQ-018 output_fc  output  DATA_WIDTH*OUTPUT_NODES  result vector, lane k at [DATA_WIDTH*k +: DATA_WIDTH].

Function
REQ-019 FSM states: IDLE, ACCUM, FINISH, OUT; every transition happens on a rising clk edge.
REQ-020 IDLE: when start=1, the block registers input_fc and relu_en, clears all accumulators, sets row index j=INPUT_NODES-1 and goes to ACCUM; start outside IDLE is ignored.
REQ-021 ACCUM: w_ready=1; on each edge with w_valid=1, every lane k adds x[j]*w[k] (full-precision signed product) into its accumulator, and j decrements.
REQ-022 Rows are consumed from the highest input index to the lowest; the transfer at j=0 moves the FSM to FINISH.
REQ-023 Cycles in ACCUM with w_valid=0 leave accumulators and j unchanged, so weight bubbles do not alter the result.
REQ-024 FINISH (one cycle, w_ready=0): per lane, r = (acc + (bias_k sign-extended << FRAC_BITS)) >>> FRAC_BITS, truncated toward minus infinity.
REQ-025 FINISH: r saturates to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if the captured relu_en=1, negative values become 0.
REQ-026 FINISH: the result is registered into output_fc, out_valid is set and the FSM moves to OUT.
REQ-027 Latency with w_valid held high: out_valid rises on the (INPUT_NODES+1)th edge after the edge that samples start.
REQ-028 OUT: output_fc and out_valid stay stable until out_valid & out_ready; on that edge out_valid clears and the FSM returns to IDLE.
REQ-029 Back-to-back: a start in the cycle after the return to IDLE is accepted; output_fc keeps its last value until the next FINISH.

Reset
REQ-030 When reset=0 (asynchronous): state=IDLE, j=INPUT_NODES-1, accumulators=0, output_fc=0, out_valid=0, busy=0, w_ready=0, captured input and relu_en=0.
REQ-031 Reset asserted mid-ACCUM or mid-OUT aborts the evaluation; no out_valid pulse follows until a new start.

Structure
REQ-032 Package fc_pkg holds: the FSM state enum, the saturate function and the clog2-based ACC_WIDTH helper.
REQ-033 Sub-module fc_mac_lane (one instance per output node, generated): accumulator register with clear and enable, and the bias/shift/saturate/ReLU datapath.

Verification (INPUT_NODES=4, OUTPUT_NODES=2, DATA_WIDTH=16, FRAC_BITS=8 unless stated)
REQ-034 Basic: inputs all 0x0100, weights all 0x0080, bias 0, w_valid=1 -> out_valid after 5 edges; both lanes = 0x0200.
REQ-035 Saturation: inputs and weights all 0x7FFF -> lanes 0x7FFF; inputs 0x7FFF with weights 0x8000 -> lanes 0x8000.
REQ-036 ReLU: inputs 0x0100, weights 0xFFC0, bias 0 -> 0xFF00 with relu_en=0; 0x0000 with relu_en=1.
REQ-037 Flow control: random w_valid gaps and out_ready held low 5 cycles -> same result as REQ-034; output_fc stable while out_ready=0; start pulses during busy ignored.
REQ-038 Reset mid-ACCUM after 2 rows, then a fresh start -> all outputs 0 during reset; the next result is identical to REQ-034.
REQ-039 Ordering: row weights equal to the row index j, inputs 0x0100 -> lane value 0x0600; the bench checks w_ready row count = INPUT_NODES.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer controller.
//   fc_state_e : controller FSM states
//   acc_width  : accumulator width that cannot overflow for a given
//                operand width and number of summed products
//   saturate   : clamp a wide signed value into a dw-bit signed range
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    OUT    = 2'd3
  } fc_state_e;

  // Each product is 2*data_width bits; summing 'nodes' of them needs
  // clog2(nodes) extra guard bits.
  function automatic int acc_width(input int data_width, input int nodes);
    return 2 * data_width + $clog2(nodes);
  endfunction

  // Values are carried in a 64-bit container so one function serves every
  // lane width; callers keep the low dw bits of the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int dw);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    if (v > max_v)
      return max_v;
    else if (v < min_v)
      return min_v;
    else
      return v;
  endfunction

endpackage

// File: rtl/fc_layer_ctrl_if.sv
// Streaming ports of the fully-connected layer controller.
//   w_valid / w_ready / weights      : weight-row stream into the block
//   out_valid / out_ready / output_fc : result vector out of the block
// master = the environment (weight source, result sink); slave = the block.
interface fc_layer_ctrl_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_NODES = 32
) ();

  logic                               w_valid;
  logic                               w_ready;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] weights;
  logic                               out_valid;
  logic                               out_ready;
  logic [DATA_WIDTH*OUTPUT_NODES-1:0] output_fc;

  modport master (
    output w_valid, weights, out_ready,
    input  w_ready, out_valid, output_fc
  );

  modport slave (
    input  w_valid, weights, out_ready,
    output w_ready, out_valid, output_fc
  );

endinterface

// File: rtl/fc_mac_lane.sv
// One output node of the fully-connected layer.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : zero the accumulator (start of a new evaluation)
//   en         : add x*w into the accumulator
//   load       : register the finished result (bias, shift, saturate, ReLU)
//   relu       : clamp negative results to zero
//   x, w, bias : signed fixed-point operands
//   result     : registered signed fixed-point output
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 39
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         load,
  input  logic                         relu,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [ACC_WIDTH-1:0]    acc_reg;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [63:0]             acc_wide;
  logic signed [63:0]             bias_wide;
  logic signed [63:0]             sum_wide;
  logic signed [DATA_WIDTH-1:0]   result_next;
  logic signed [DATA_WIDTH-1:0]   result_reg;

  assign prod     = x * w;
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  // The bias has FRAC_BITS fraction bits while the accumulator has
  // 2*FRAC_BITS, so the bias is aligned up before the sum is scaled back.
  assign acc_wide  = {{(64-ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg};
  assign bias_wide = {{(64-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign sum_wide  = acc_wide + (bias_wide <<< FRAC_BITS);

  // Arithmetic shift truncates toward minus infinity.
  always_comb begin
    result_next = DATA_WIDTH'(saturate(sum_wide >>> FRAC_BITS, DATA_WIDTH));
    if (relu && result_next[DATA_WIDTH-1])
      result_next = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg    <= '0;
      result_reg <= '0;
    end else begin
      if (clr)
        acc_reg <= '0;
      else if (en)
        acc_reg <= acc_reg + prod_ext;
      if (load)
        result_reg <= result_next;
    end
  end

  assign result = result_reg;

endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer controller: one MAC lane per output node; weight
// rows stream in from the highest input index down to zero, then bias,
// scaling, saturation and optional ReLU are applied and the vector is held
// until the consumer takes it.
//   clk, reset : clock, asynchronous active-low reset
//   start      : begin an evaluation (honoured in IDLE only)
//   relu_en    : ReLU enable, captured with start
//   input_fc   : input vector, captured with start
//   bias       : per-node bias, used in the FINISH cycle
//   busy       : high whenever not IDLE
//   bus        : weight stream and result handshake (slave side)
module fc_layer_ctrl
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int INPUT_NODES  = 100,
  parameter int OUTPUT_NODES = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              relu_en,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] bias,
  output logic                              busy,
  fc_layer_ctrl_if.slave                    bus
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, INPUT_NODES);
  localparam int JW        = $clog2(INPUT_NODES);
  localparam logic [JW-1:0] J_LAST = JW'(INPUT_NODES - 1);

  fc_state_e                        state_reg;
  logic [JW-1:0]                    j_reg;
  logic [DATA_WIDTH*INPUT_NODES-1:0] x_reg;
  logic                             relu_reg;
  logic                             busy_reg;
  logic                             w_ready_reg;
  logic                             out_valid_reg;

  logic [DATA_WIDTH-1:0]            x_arr [INPUT_NODES];
  logic [DATA_WIDTH-1:0]            x_cur;
  logic                             acc_clr;
  logic                             acc_en;
  logic                             res_load;

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_NODES; gi++) begin : g_x
      assign x_arr[gi] = x_reg[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  assign x_cur    = x_arr[j_reg];
  assign acc_clr  = (state_reg == IDLE) && start;
  assign acc_en   = (state_reg == ACCUM) && bus.w_valid;
  assign res_load = (state_reg == FINISH);

  // Status outputs are registered alongside the state so that they change
  // exactly on the edges that move the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      j_reg         <= J_LAST;
      x_reg         <= '0;
      relu_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      w_ready_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            x_reg       <= input_fc;
            relu_reg    <= relu_en;
            j_reg       <= J_LAST;
            busy_reg    <= 1'b1;
            w_ready_reg <= 1'b1;
            state_reg   <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.w_valid) begin
            if (j_reg == '0) begin
              w_ready_reg <= 1'b0;
              state_reg   <= FINISH;
            end else begin
              j_reg <= j_reg - JW'(1);
            end
          end
        end
        FINISH: begin
          out_valid_reg <= 1'b1;
          state_reg     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  generate
    for (gi = 0; gi < OUTPUT_NODES; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_result;

      fc_mac_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .load   (res_load),
        .relu   (relu_reg),
        .x      (x_cur),
        .w      (bus.weights[DATA_WIDTH*gi +: DATA_WIDTH]),
        .bias   (bias[DATA_WIDTH*gi +: DATA_WIDTH]),
        .result (lane_result)
      );

      assign bus.output_fc[DATA_WIDTH*gi +: DATA_WIDTH] = lane_result;
    end
  endgenerate

  assign busy          = busy_reg;
  assign bus.w_ready   = w_ready_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Self-checking bench for fc_layer_ctrl with 4 inputs and 2 output lanes.
// The driver pushes the hand-computed result of each evaluation into a
// queue; an independent monitor pops and compares on every output transfer.
module tb_fc_layer_ctrl;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int IN = 4;
  localparam int ON = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          relu_en = 1'b0;
  logic [63:0]   input_fc = '0;
  logic [31:0]   bias = '0;
  logic          busy;

  fc_layer_ctrl_if #(.DATA_WIDTH(DW), .OUTPUT_NODES(ON)) bus ();

  fc_layer_ctrl #(
    .DATA_WIDTH   (DW),
    .FRAC_BITS    (FB),
    .INPUT_NODES  (IN),
    .OUTPUT_NODES (ON)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .relu_en  (relu_en),
    .input_fc (input_fc),
    .bias     (bias),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  int          n_out = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rows [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: samples 2 time units after the falling edge, when both the
  // driver's inputs and the DUT's registered outputs are settled.
  initial begin : monitor
    logic        ov_prev;
    logic        hold_ok;
    logic [31:0] held;
    logic [31:0] e;
    ov_prev = 1'b0;
    hold_ok = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        ov_prev = 1'b0;
        hold_ok = 1'b0;
      end else begin
        if (bus.out_valid && !ov_prev) rise_cyc = cyc;
        ov_prev = bus.out_valid;
        if (bus.out_valid) begin
          if (!bus.out_ready) begin
            if (hold_ok) check("hold_stable", {32'h0, bus.output_fc}, {32'h0, held});
            else begin
              held    = bus.output_fc;
              hold_ok = 1'b1;
            end
          end else begin
            hold_ok = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              $display("FAIL unexpected_out: got %h expected no output", bus.output_fc);
            end else begin
              e = exp_q.pop_front();
              n_out++;
              $display("out %0d: output_fc=%h expected=%h", n_out, bus.output_fc, e);
              check("output_fc", {32'h0, bus.output_fc}, {32'h0, e});
            end
          end
        end
      end
    end
  end

  // One layer evaluation: start, stream rows[3]..rows[0], accept the output.
  task automatic run_layer(input string name, input logic [63:0] x,
                           input logic [31:0] b, input logic relu,
                           input logic [31:0] exp_out, input bit gaps,
                           input int hold, input bit stray, input bit chk_lat);
    int r;
    int guard;
    int rows_seen;
    int h;
    int start_cyc;
    bit fire;
    bit done;
    exp_q.push_back(exp_out);
    @(negedge clk);
    input_fc = x;
    bias     = b;
    relu_en  = relu;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
    r = IN - 1;
    rows_seen = 0;
    guard = 0;
    while (r >= 0 && guard < 200) begin
      @(negedge clk);
      bus.weights = rows[r];
      bus.w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (stray) begin
        start    = ($urandom_range(0, 2) == 0);
        input_fc = {$urandom, $urandom};
      end
      fire = bus.w_valid && bus.w_ready;
      @(posedge clk);
      if (fire) begin
        r--;
        rows_seen++;
      end
      guard++;
    end
    check({name, "_rows"}, 64'(rows_seen), 64'(IN));
    // One more row offered: the block must not take it.
    @(negedge clk);
    start       = 1'b0;
    bus.w_valid = 1'b1;
    check({name, "_w_ready_off"}, {63'h0, bus.w_ready}, 64'h0);
    h = hold;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      bus.w_valid = 1'b0;
      if (bus.out_valid && h > 0) begin
        bus.out_ready = 1'b0;
        start = stray;
        h--;
      end else begin
        bus.out_ready = bus.out_valid;
        start = 1'b0;
      end
      fire = bus.out_valid && bus.out_ready;
      @(posedge clk);
      if (fire) done = 1'b1;
      guard++;
    end
    #1;
    bus.out_ready = 1'b0;
    start = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got no output expected output within bound", name);
    end
    if (chk_lat) check({name, "_latency"}, 64'(rise_cyc - start_cyc), 64'(IN + 1));
  endtask

  task automatic fill_rows(input logic [31:0] v);
    for (int j = 0; j < IN; j++) rows[j] = v;
  endtask

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int seen;
    bus.w_valid   = 1'b0;
    bus.weights   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_w_ready", {63'h0, bus.w_ready}, 64'h0);
    check("rst_output_fc", {32'h0, bus.output_fc}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic: 4 * (1.0 * 0.5) = 2.0
    fill_rows(32'h0080_0080);
    run_layer("basic", 64'h0100_0100_0100_0100, 32'h0, 1'b0, 32'h0200_0200, 0, 0, 0, 1);
    @(negedge clk);
    check("idle_busy", {63'h0, busy}, 64'h0);
    check("idle_keep_out", {32'h0, bus.output_fc}, 64'h0000_0000_0200_0200);

    // Saturation, issued back to back
    fill_rows(32'h7FFF_7FFF);
    run_layer("sat_pos", 64'h7FFF_7FFF_7FFF_7FFF, 32'h0, 1'b0, 32'h7FFF_7FFF, 0, 0, 0, 1);
    fill_rows(32'h8000_8000);
    run_layer("sat_neg", 64'h7FFF_7FFF_7FFF_7FFF, 32'h0, 1'b0, 32'h8000_8000, 0, 0, 0, 1);

    // ReLU: 4 * (1.0 * -0.25) = -1.0
    fill_rows(32'hFFC0_FFC0);
    run_layer("relu_off", 64'h0100_0100_0100_0100, 32'h0, 1'b0, 32'hFF00_FF00, 0, 0, 0, 1);
    run_layer("relu_on", 64'h0100_0100_0100_0100, 32'h0, 1'b1, 32'h0000_0000, 0, 0, 0, 1);

    // Bias: lane0 2.0 + 1.0, lane1 2.0 - 1.0
    fill_rows(32'h0080_0080);
    run_layer("bias", 64'h0100_0100_0100_0100, 32'hFF00_0100, 1'b0, 32'h0100_0300, 0, 0, 0, 1);

    // Truncation toward minus infinity: lane0 -4/256 -> -1, lane1 +4/256 -> 0
    fill_rows(32'h0001_FFFF);
    run_layer("trunc", 64'h0001_0001_0001_0001, 32'h0, 1'b0, 32'h0000_FFFF, 0, 0, 0, 1);

    // Flow control: weight bubbles, stray starts, output held 5 cycles
    fill_rows(32'h0080_0080);
    run_layer("flow", 64'h0100_0100_0100_0100, 32'h0, 1'b0, 32'h0200_0200, 1, 5, 1, 0);

    // Reset mid-ACCUM after two rows
    @(negedge clk);
    input_fc = 64'h0100_0100_0100_0100;
    relu_en  = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bus.weights = 32'h0080_0080;
      bus.w_valid = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("mid_rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    check("mid_rst_w_ready", {63'h0, bus.w_ready}, 64'h0);
    check("mid_rst_output_fc", {32'h0, bus.output_fc}, 64'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #2;
      if (bus.out_valid || busy) seen++;
    end
    bus.w_valid = 1'b0;
    check("no_out_after_reset", 64'(seen), 64'h0);
    run_layer("after_reset", 64'h0100_0100_0100_0100, 32'h0, 1'b0, 32'h0200_0200, 0, 0, 0, 1);

    // Ordering: weight of row j is j (fixed point), inputs 1.0 -> 0+1+2+3 = 6
    for (int j = 0; j < IN; j++) rows[j] = {16'(j * 256), 16'(j * 256)};
    run_layer("order_sum", 64'h0100_0100_0100_0100, 32'h0, 1'b0, 32'h0600_0600, 0, 0, 0, 1);
    // Only input node 3 is non-zero; it must meet the first row delivered
    for (int j = 0; j < IN; j++) rows[j] = {16'(j * 512), 16'(j * 256)};
    run_layer("order_first", 64'h0100_0000_0000_0000, 32'h0, 1'b0, 32'h0600_0300, 0, 0, 0, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
